// File: rtl/a2d_slv.sv
// rtl/a2d_slv.sv - SPI slave front end for an eight-channel A2D conversion register file
module a2d_slv #(
    parameter int   SYNC_STAGES = 2,
    parameter logic IDLE_MISO   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic        ld_en,
    input  logic [2:0]  ld_chnnl,
    input  logic [11:0] ld_val,
    output logic        cmd_vld,
    output logic [15:0] cmd_rcvd,
    output logic        frame_err,
    output logic [2:0]  cur_chnnl
);

    typedef enum logic {IDLE, SHIFT} state_t;

    // Cycles after reset until the synchronizer chain holds real pin values.
    localparam logic [2:0] FLUSH_CYC = 3'(SYNC_STAGES + 1);

    state_t state, next_state;

    logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
    logic        ss_d, sclk_d;
    logic        ss_s, sclk_s, mosi_s;
    logic        ss_fall, ss_rise, sclk_fall, sclk_rise;
    logic [2:0]  flush_cnt;
    logic        flushed;
    logic        armed;
    logic        first_fall;
    logic [4:0]  bit_cnt;
    logic [15:0] tx_shft, rx_shft;
    logic [11:0] chan_reg [8];

    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign flushed   = (flush_cnt == FLUSH_CYC);
    // A frame may only start once SS_n has been seen idle after reset, so a
    // transfer already running at reset release is ignored.
    assign ss_fall   = armed && (state == IDLE) && ss_d && !ss_s;
    assign ss_rise   = ss_s && !ss_d;
    assign sclk_fall = sclk_d && !sclk_s;
    assign sclk_rise = sclk_s && !sclk_d;

    assign MISO = ((state == SHIFT) && !ss_s) ? tx_shft[15] : IDLE_MISO;

    // Synchronize the asynchronous SPI pins and keep one extra stage for edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            ss_sync   <= '1;
            sclk_sync <= '1;
            mosi_sync <= '1;
            ss_d      <= 1'b1;
            sclk_d    <= 1'b1;
        end else begin
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            ss_d      <= ss_s;
            sclk_d    <= sclk_s;
        end
    end

    // Frame state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Frame begins on synchronized SS_n fall and ends on its rise.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (ss_fall) next_state = SHIFT;
            SHIFT:   if (ss_rise) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Shift registers, bit counter, channel registers and frame results.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt  <= 3'd0;
            armed      <= 1'b0;
            first_fall <= 1'b0;
            bit_cnt    <= 5'd0;
            tx_shft    <= 16'h0000;
            rx_shft    <= 16'h0000;
            cmd_rcvd   <= 16'h0000;
            cur_chnnl  <= 3'd0;
            cmd_vld    <= 1'b0;
            frame_err  <= 1'b0;
            for (int i = 0; i < 8; i++) chan_reg[i] <= 12'h000;
        end else begin
            cmd_vld   <= 1'b0;
            frame_err <= 1'b0;
            if (ld_en) chan_reg[ld_chnnl] <= ld_val;
            if (!flushed) flush_cnt <= flush_cnt + 3'd1;
            if (flushed && ss_s && ss_d) armed <= 1'b1;
            if (ss_fall) begin
                tx_shft    <= {4'b0000, ~chan_reg[cur_chnnl]};
                bit_cnt    <= 5'd0;
                first_fall <= 1'b1;
            end else if (state == SHIFT) begin
                if (ss_rise) begin
                    if (bit_cnt == 5'd16) begin
                        cmd_rcvd <= rx_shft;
                        if (rx_shft[15:14] == 2'b00) cur_chnnl <= rx_shft[13:11];
                        cmd_vld <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end else begin
                    // The first fall only marks the start; bit 15 is already on MISO.
                    if (sclk_fall) begin
                        if (first_fall) first_fall <= 1'b0;
                        else            tx_shft    <= {tx_shft[14:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        rx_shft <= {rx_shft[14:0], mosi_s};
                        if (bit_cnt != 5'd17) bit_cnt <= bit_cnt + 5'd1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/a2d_slv.md
A2D_SLV -- requirements
Module: a2d_slv

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2 (legal 2..4): synchronizer depth on SS_n, SCLK and MOSI.
REQ-002 SHALL have parameter IDLE_MISO, default 1'b1: MISO level while SS_n is high.
REQ-003 clk  in  1  system clock; sole clock; all state changes on posedge clk.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 SS_n  in  1  SPI slave select, active low, asynchronous to clk.
REQ-006 SCLK  in  1  SPI clock, asynchronous to clk, idles high.
REQ-007 MOSI  in  1  SPI data from master, MSB first.
REQ-008 MISO  out  1  SPI data to master, MSB first.
REQ-009 ld_en  in  1  when high, write ld_val into the channel register selected by ld_chnnl.
REQ-010 ld_chnnl  in  3  channel register index for a load.
REQ-011 ld_val  in  12  conversion value to store.
REQ-012 cmd_vld  out  1  single-cycle pulse: a valid 16-bit frame completed.
REQ-013 cmd_rcvd  out  16  last valid frame received on MOSI.
REQ-014 frame_err  out  1  single-cycle pulse: SS_n deasserted with bit count not equal to 16.
REQ-015 cur_chnnl  out  3  channel latched from the last valid command.

Function
REQ-016 SS_n, SCLK and MOSI SHALL pass through SYNC_STAGES flops, plus one further flop used only for edge detection; SCLK rise, SCLK fall and SS_n fall/rise SHALL be detected from the last two flops.
REQ-017 SHALL be correct for SCLK high and low phases of at least SYNC_STAGES+2 clk cycles each; SPI mode is CPOL=1, CPHA=1.
REQ-018 State machine SHALL have states IDLE and SHIFT; IDLE->SHIFT on synchronized SS_n fall; SHIFT->IDLE on synchronized SS_n rise.
REQ-019 On SS_n fall, tx_shft[15:0] SHALL load {4'b0000, ~chan_reg[cur_chnnl]}, and MISO SHALL present tx_shft[15] from the next cycle onward.
REQ-020 In SHIFT, each SCLK fall SHALL shift tx_shft left by one (LSB fill 0), except the first fall after SS_n fall, which SHALL leave tx_shft unchanged.
REQ-021 In SHIFT, each SCLK rise SHALL shift the synchronized MOSI into rx_shft LSB and increment a 5-bit bit_cnt; bit_cnt SHALL saturate at 17.
REQ-022 bit_cnt SHALL clear on SS_n fall.
REQ-023 On SS_n rise with bit_cnt==16:
  - cmd_rcvd SHALL take rx_shft;
  - cur_chnnl SHALL take rx_shft[13:11] if rx_shft[15:14]==2'b00, otherwise it SHALL hold;
  - cmd_vld SHALL pulse for 1 cycle.
REQ-024 On SS_n rise with bit_cnt!=16, frame_err SHALL pulse for 1 cycle and cmd_rcvd and cur_chnnl SHALL hold.
REQ-025 Protocol consequence: the first frame selects the channel; the second frame returns the inverted 12-bit value of that channel in bits [11:0], so the master's complement of rd_data[11:0] recovers ld_val.
REQ-026 ld_en SHALL update chan_reg on the next clk edge in any state.
REQ-027 If ld_en and the SS_n-fall snapshot occur in the same cycle on the same channel, the snapshot SHALL use the old value.
REQ-028 A load during SHIFT SHALL never alter the in-flight tx_shft.
REQ-029 MISO SHALL equal IDLE_MISO whenever the synchronized SS_n is high.
REQ-030 SCLK edges while SS_n is high SHALL be ignored and SHALL NOT change any register.

Reset
REQ-031 When rst is high at a clk edge, the block SHALL clear as follows:
  - state=IDLE, bit_cnt=0, tx_shft=0, rx_shft=0;
  - all eight chan_reg=12'h000;
  - cur_chnnl=0, cmd_rcvd=16'h0000;
  - cmd_vld=0, frame_err=0, MISO=IDLE_MISO;
  - all synchronizer flops=1 (SS_n idle, SCLK idle).
REQ-032 rst asserted mid-frame SHALL abort the frame without a frame_err or cmd_vld pulse; the next SS_n fall after rst deasserts SHALL start a clean frame.
REQ-033 Ignoring the SS_n level at rst release: a frame already in progress when rst deasserts SHALL NOT be received, and the block SHALL start only on a fresh SS_n fall.

Verification
REQ-034 Load ch3=12'hA5C; frame 1 MOSI=16'h1800; frame 2 MOSI=16'h1800 -> frame 1 cmd_vld, cur_chnnl=3; frame 2 MISO word=16'h05A3.
REQ-035 After reset, a frame with any MOSI value -> MISO word=16'h0FFF; cmd_vld pulses once; cmd_rcvd = MOSI word.
REQ-036 SS_n raised after 9 SCLK rises -> frame_err pulses once, cmd_vld stays 0, cur_chnnl and cmd_rcvd unchanged; next full frame is received correctly.
REQ-037 Load ch5 in the same cycle as the SS_n-fall snapshot with ch5 selected -> current frame returns the old value, next frame returns the new value.
REQ-038 Command 16'hC800 (bits[15:14]=11) -> cmd_vld pulses, cmd_rcvd=16'hC800, cur_chnnl unchanged.
REQ-039 rst pulsed after 8 SCLK rises -> no pulse on either flag; all registers at reset values; a following frame 16'h0000 then 16'h0000 returns 16'h0FFF.
